// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Multiply uses radix-4 Booth (WIDTH/2 steps). Divide uses non-restoring division on magnitudes (WIDTH steps).
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH / 2);
    localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MULT_RUN,
        DIV_RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] product, mcand, pp, product_next;
    logic [WIDTH:0]     mplier;
    logic [WIDTH:0]     rem, rem_shift, rem_next;
    logic [WIDTH-1:0]   quo, quo_next;
    logic [WIDTH-1:0]   mag_a_in, mag_b;
    logic [WIDTH-1:0]   div_result;
    logic               div_exc, mult_ovf;
    logic               start_mult, start_div;
    logic               mult_step, div_step, mult_fin, div_fin;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    // A start always wins over whatever is in flight; multiply has priority over divide.
    always_comb begin
        state_next     = state;
        start_mult     = 1'b0;
        start_div      = 1'b0;
        mult_step      = 1'b0;
        div_step       = 1'b0;
        mult_fin       = 1'b0;
        div_fin        = 1'b0;
        data_resultRDY = (state == DONE);
        if (ctrl_MULT) begin
            start_mult = 1'b1;
            state_next = MULT_RUN;
        end else if (ctrl_DIV) begin
            start_div  = 1'b1;
            state_next = DIV_RUN;
        end else begin
            case (state)
                MULT_RUN: begin
                    if (count == MULT_LAST) begin
                        mult_fin   = 1'b1;
                        state_next = DONE;
                    end else begin
                        mult_step = 1'b1;
                    end
                end
                DIV_RUN: begin
                    if (count == DIV_LAST) begin
                        div_fin    = 1'b1;
                        state_next = DONE;
                    end else begin
                        div_step = 1'b1;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Booth digit from the low three multiplier bits; the multiplicand is pre-shifted each step.
    always_comb begin
        pp = '0;
        case (mplier[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        product_next = product + pp;
        mult_ovf     = !((&product[2*WIDTH-1:WIDTH-1]) || (~|product[2*WIDTH-1:WIDTH-1]));
    end

    always_comb begin
        mag_a_in  = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        mag_b     = b_reg[WIDTH-1] ? (~b_reg + 1'b1) : b_reg;
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_next  = rem[WIDTH] ? (rem_shift + {1'b0, mag_b}) : (rem_shift - {1'b0, mag_b});
        quo_next  = {quo[WIDTH-2:0], ~rem_next[WIDTH]};
        div_exc   = (b_reg == '0) ||
                    ((a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_reg));
        if (b_reg == '0)
            div_result = '0;
        else if (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])
            div_result = ~quo + 1'b1;
        else
            div_result = quo;
    end

    // Results only change on the edge entering DONE; they persist through IDLE and new starts.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count          <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            product        <= '0;
            mcand          <= '0;
            mplier         <= '0;
            rem            <= '0;
            quo            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            if (start_mult || start_div) begin
                a_reg <= data_operandA;
                b_reg <= data_operandB;
                count <= '0;
            end
            if (start_mult) begin
                product <= '0;
                mcand   <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                mplier  <= {data_operandB, 1'b0};
            end
            if (start_div) begin
                rem <= '0;
                quo <= mag_a_in;
            end
            if (mult_step || div_step)
                count <= count + CW'(1);
            if (mult_step) begin
                product <= product_next;
                mcand   <= mcand << 2;
                mplier  <= {{2{mplier[WIDTH]}}, mplier[WIDTH:2]};
            end
            if (div_step) begin
                rem <= rem_next;
                quo <= quo_next;
            end
            if (mult_fin) begin
                data_result    <= product[WIDTH-1:0];
                data_exception <= mult_ovf;
            end
            if (div_fin) begin
                data_result    <= div_result;
                data_exception <= div_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: vector table plus random ops through a scoreboard, then abort/restart and mid-op reset sequences.
module tb_multdiv_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           lat;
    } exp_t;

    typedef struct {
        logic         m;
        logic         d;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         exc;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] data_operandA, data_operandB;
    logic         ctrl_MULT, ctrl_DIV;
    logic [W-1:0] data_result;
    logic         data_exception, data_resultRDY;

    int           compared = 0;
    int           mismatched = 0;
    exp_t         sb[$];
    logic [W-1:0] last_res;
    logic         last_exc;
    vec_t         vecs[8];

    multdiv_unit #(.WIDTH(W)) dut (
        .clk            (clk),
        .clr            (clr),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p;
        if (m) begin
            p     = longint'(signed'(a)) * longint'(signed'(b));
            e.res = p[31:0];
            e.exc = !((p[63:31] == '0) || (&p[63:31]));
            e.lat = 17;
        end else begin
            e.lat = 33;
            if (b == '0) begin
                e.res = '0;
                e.exc = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.res = 32'h8000_0000;
                e.exc = 1'b1;
            end else begin
                e.res = 32'(int'(signed'(a)) / int'(signed'(b)));
                e.exc = 1'b0;
            end
        end
        return e;
    endfunction

    // Drives one start cycle, queues the expectation, scrambles operands afterwards.
    task automatic applyStimulus(input logic m, input logic d, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input exp_t e);
        @(negedge clk);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        sb.push_back(e);
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        checkVal("hold_after_start", {32'b0, data_result}, {32'b0, last_res});
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        int   k;
        if (sb.size() == 0) begin
            checkVal({name, "_scoreboard_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        for (k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (data_resultRDY) break;
        end
        if (k > 80) begin
            checkVal({name, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        checkVal({name, "_latency"}, 64'(k), 64'(e.lat));
        checkVal({name, "_result"}, {32'b0, data_result}, {32'b0, e.res});
        checkVal({name, "_exc"}, {63'b0, data_exception}, {63'b0, e.exc});
        last_res = e.res;
        last_exc = e.exc;
        @(negedge clk);
        checkVal({name, "_rdy_drop"}, {63'b0, data_resultRDY}, 64'd0);
        checkVal({name, "_hold"}, {32'b0, data_result}, {32'b0, e.res});
    endtask

    initial begin
        int   pulses;
        exp_t e;
        logic m;
        logic [W-1:0] a, b;

        vecs[0] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 17};
        vecs[1] = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 17};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 17};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33};
        vecs[4] = '{1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33};
        vecs[5] = '{1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1, 33};
        vecs[6] = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        vecs[7] = '{1'b1, 1'b1, 32'd6,          32'd3,         32'd18,        1'b0, 17};

        clr           = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        last_res      = '0;
        last_exc      = 1'b0;
        #12;
        checkVal("reset_result", {32'b0, data_result}, 64'd0);
        checkVal("reset_exc", {63'b0, data_exception}, 64'd0);
        checkVal("reset_rdy", {63'b0, data_resultRDY}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("idle_no_rdy", {63'b0, data_resultRDY}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                          '{vecs[i].res, vecs[i].exc, vecs[i].lat});
            checkOutput($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            m = i[0];
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) b = ~b + 1'b1;
            e = model(m, a, b);
            applyStimulus(m, ~m, a, b, e);
            checkOutput($sformatf("rand%0d", i));
        end

        // Divide aborted at edge 10 by a multiply; only the multiply may ever report.
        @(negedge clk);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(negedge clk);
        ctrl_DIV = 1'b0;
        pulses   = 0;
        repeat (9) begin
            @(negedge clk);
            if (data_resultRDY) pulses++;
        end
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        sb.push_back('{32'd12, 1'b0, 17});
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        checkOutput("abort");
        repeat (40) begin
            @(negedge clk);
            if (data_resultRDY) pulses++;
        end
        checkVal("abort_no_extra_rdy", 64'(pulses), 64'd0);
        checkVal("abort_result_held", {32'b0, data_result}, 64'd12);

        // Asynchronous reset between edges during a multiply.
        @(negedge clk);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'hFFFF_FFFA;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        repeat (5) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        checkVal("midreset_result", {32'b0, data_result}, 64'd0);
        checkVal("midreset_exc", {63'b0, data_exception}, 64'd0);
        checkVal("midreset_rdy", {63'b0, data_resultRDY}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        clr      = 1'b0;
        last_res = '0;
        last_exc = 1'b0;
        pulses   = 0;
        repeat (30) begin
            @(negedge clk);
            if (data_resultRDY) pulses++;
        end
        checkVal("midreset_no_rdy", 64'(pulses), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, '{32'hFFFF_FFD6, 1'b0, 17});
        checkOutput("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed integer multiply/divide unit that sits beside the ALU in the execute stage.
- Latches its operands into enable flops on a start pulse and iterates internally.
- Returns a single-cycle ready pulse with the result and an exception flag.
- The pipeline stalls on the ready pulse, and that pulse drives the write enable of the downstream result latch.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and >= 4

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  asynchronous active-high reset
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  start-multiply pulse, sampled on rising edge
ctrl_DIV  input  1  start-divide pulse, sampled on rising edge
data_result  output  WIDTH  product low WIDTH bits, or quotient
data_exception  output  1  overflow / divide-by-zero flag, valid with result
data_resultRDY  output  1  one-cycle pulse: result and exception valid

Behaviour:
- Reset:
  - clr asynchronously forces data_result=0, data_exception=0, data_resultRDY=0, FSM=IDLE, iteration counter=0, operand latches=0.
  - clr asserted mid-operation aborts it; no RDY pulse follows.
- FSM states: IDLE, MULT_RUN, DIV_RUN, DONE.
- Start:
  - A start edge is a rising edge with ctrl_MULT or ctrl_DIV high.
  - On a start edge, operands are latched, the counter is cleared, and the FSM enters MULT_RUN or DIV_RUN.
  - Operand inputs are don't-care after the start edge.
- Simultaneous starts: ctrl_MULT and ctrl_DIV both high -> multiply wins, divide ignored.
- Restart while busy: a start edge while in MULT_RUN, DIV_RUN or DONE aborts the current operation and restarts with the new operands. No RDY pulse is issued for the aborted operation.
- Multiply:
  - Radix-4 Booth, 2*WIDTH-bit product register, one Booth step per cycle, WIDTH/2 steps.
  - data_resultRDY is high for exactly the cycle after rising edge WIDTH/2+1 counted from the start edge (edge 17 for WIDTH=32).
  - data_result = low WIDTH bits of the exact signed product.
  - data_exception = 1 iff the upper WIDTH+1 bits of the full product are not all equal (signed overflow).
- Divide:
  - Non-restoring on operand magnitudes, one quotient bit per cycle, WIDTH steps.
  - Sign is applied at the end; the quotient truncates toward zero and the remainder is discarded.
  - data_resultRDY is high for the cycle after rising edge WIDTH+1 from the start edge (edge 33).
  - Divisor == 0 -> data_result=0, data_exception=1, with the same latency.
  - Dividend == most-negative and divisor == -1 -> data_result=most-negative value, data_exception=1.
- DONE: lasts one cycle with RDY=1, then returns to IDLE and RDY drops to 0.
- Output hold: data_result and data_exception are updated only on the edge entering DONE. They hold their values through IDLE until the next completion; they are not cleared by a start.
- The counter never wraps: it stops at its terminal count, and the FSM leaves RUN exactly once per operation.
- No start pending: the unit stays in IDLE indefinitely with outputs held.

Test Plan:
- Basic multiply:
  - Stimulus: clr pulse, then ctrl_MULT one cycle with A=7, B=-6 (0xFFFFFFFA).
  - Response: RDY pulses exactly 17 edges later; result=0xFFFFFFD6, exception=0; RDY low on the next cycle.
- Multiply overflow:
  - Stimulus: A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
  - Stimulus: A=0x80000000, B=1 -> result=0x80000000, exception=0.
- Signed divide:
  - Stimulus: ctrl_DIV with A=-7, B=2.
  - Response: RDY exactly 33 edges later; result=0xFFFFFFFD (-3), exception=0.
  - Also check A=100, B=-7 -> result=0xFFFFFFF2 (-14).
- Divide exceptions:
  - Stimulus: A=5, B=0 -> result=0, exception=1 at edge 33.
  - Stimulus: A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- Abort/restart and priority:
  - Stimulus: start DIV with A=100, B=7; at edge 10 pulse ctrl_MULT with A=3, B=4.
  - Response: a single RDY pulse 17 edges after the second start, result=12; no divide result ever appears.
  - Stimulus: ctrl_MULT and ctrl_DIV high together with A=6, B=3 -> result=18.
- Reset mid-operation:
  - Stimulus: assert clr asynchronously (between edges) during MULT_RUN.
  - Response: outputs drop to 0 immediately and no RDY follows.
  - After release, a new start completes normally with correct latency.
